// File: rtl/bus_pkg.sv
// Shared types and constants for the 8-bit register bus and its transfer controller.
package bus_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

   localparam int unsigned REG_A   = 0;
   localparam int unsigned REG_B   = 1;
   localparam int unsigned REG_OUT = 2;
   localparam int unsigned REG_TMP = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } xfer_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Gated binary-to-one-hot decoder used for the register enable and latch strobes.
module onehot_dec #(
   parameter int unsigned NUM_OUT = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_OUT)
) (
   input  logic [IDX_W-1:0]   idx,
   input  logic               gate,
   output logic [NUM_OUT-1:0] onehot_c
);

   always_comb begin
      onehot_c = '0;
      if (gate) onehot_c[idx] = 1'b1;
   end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer initiator: sequences one source-drive / destination-latch transfer per request.
module bus_xfer_ctrl
   import bus_pkg::*;
#(
   parameter int unsigned  NUM_REGS   = 4,
   parameter int unsigned  DATA_WIDTH = DEFAULT_DATA_WIDTH,
   localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [IDX_W-1:0]      req_src,
   input  logic [IDX_W-1:0]      req_dst,
   input  logic                  req_imm_en,
   input  logic [DATA_WIDTH-1:0] req_imm,
   output logic [NUM_REGS-1:0]   enable,
   output logic [NUM_REGS-1:0]   latch,
   output logic                  imm_drive,
   output logic [DATA_WIDTH-1:0] imm_out,
   input  logic [DATA_WIDTH-1:0] bus,
   output logic [DATA_WIDTH-1:0] last_data,
   output logic                  done,
   output logic                  err
);

   xfer_state_t         state_q;
   xfer_state_t         state_nxt;
   logic [IDX_W-1:0]    src_q;
   logic [IDX_W-1:0]    dst_q;
   logic                imm_en_q;
   logic                bad_q;

   logic                accept_c;
   logic                bad_req_c;
   logic [IDX_W-1:0]    src_sel_c;
   logic [IDX_W-1:0]    dst_sel_c;
   logic                imm_sel_c;
   logic                bad_sel_c;
   logic                drive_c;
   logic                en_gate_c;
   logic                lat_gate_c;
   logic                imm_drive_nxt;
   logic                done_nxt;
   logic                err_nxt;
   logic [NUM_REGS-1:0] enable_nxt;
   logic [NUM_REGS-1:0] latch_nxt;

   assign accept_c  = (state_q == IDLE) && req_valid;
   assign bad_req_c = !req_imm_en && (req_src == req_dst);
   assign req_ready = (state_q == IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_nxt = bad_req_c ? DONE : SETUP;
         SETUP:   state_nxt = LATCH;
         LATCH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are computed for the next cycle and registered; on the accept edge
   // the request fields are taken straight from the port since the capture is not yet visible.
   always_comb begin
      src_sel_c     = accept_c ? req_src    : src_q;
      dst_sel_c     = accept_c ? req_dst    : dst_q;
      imm_sel_c     = accept_c ? req_imm_en : imm_en_q;
      bad_sel_c     = accept_c ? bad_req_c  : bad_q;
      drive_c       = (state_nxt == SETUP) || (state_nxt == LATCH);
      en_gate_c     = drive_c && !imm_sel_c;
      imm_drive_nxt = drive_c && imm_sel_c;
      lat_gate_c    = (state_nxt == LATCH);
      done_nxt      = (state_nxt == DONE) && !bad_sel_c;
      err_nxt       = (state_nxt == DONE) && bad_sel_c;
   end

   onehot_dec #(.NUM_OUT(NUM_REGS), .IDX_W(IDX_W)) u_enable_dec (
      .idx      (src_sel_c),
      .gate     (en_gate_c),
      .onehot_c (enable_nxt)
   );

   onehot_dec #(.NUM_OUT(NUM_REGS), .IDX_W(IDX_W)) u_latch_dec (
      .idx      (dst_sel_c),
      .gate     (lat_gate_c),
      .onehot_c (latch_nxt)
   );

   // Request capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         src_q    <= '0;
         dst_q    <= '0;
         imm_en_q <= 1'b0;
         bad_q    <= 1'b0;
         imm_out  <= '0;
      end else if (accept_c) begin
         src_q    <= req_src;
         dst_q    <= req_dst;
         imm_en_q <= req_imm_en;
         bad_q    <= bad_req_c;
         imm_out  <= req_imm;
      end
   end

   // Registered strobes and status; last_data samples the bus on the latch edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable    <= '0;
         latch     <= '0;
         imm_drive <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         last_data <= '0;
      end else begin
         enable    <= enable_nxt;
         latch     <= latch_nxt;
         imm_drive <= imm_drive_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         if (state_q == LATCH) last_data <= bus;
      end
   end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed vector table, reset corner cases and
// randomized requests against a register-file level reference model.
module tb_bus_xfer_ctrl;
   import bus_pkg::*;

   typedef struct {
      logic       ie;
      logic [1:0] s;
      logic [1:0] d;
      logic [7:0] imm;
      logic [7:0] last;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_src;
   logic [1:0] req_dst;
   logic       req_imm_en;
   logic [7:0] req_imm;
   logic [3:0] enable;
   logic [3:0] latch;
   logic       imm_drive;
   logic [7:0] imm_out;
   logic [7:0] bus;
   logic [7:0] last_data;
   logic       done;
   logic       err;

   int n_chk = 0;
   int n_pass = 0;
   int viol = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   // bus-side register file (environment) and the bench's expected register contents
   logic [7:0] regs   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] m_regs [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] m_last = 8'h00;

   bus_xfer_ctrl #(.NUM_REGS(4), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_src    (req_src),
      .req_dst    (req_dst),
      .req_imm_en (req_imm_en),
      .req_imm    (req_imm),
      .enable     (enable),
      .latch      (latch),
      .imm_drive  (imm_drive),
      .imm_out    (imm_out),
      .bus        (bus),
      .last_data  (last_data),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      bus = 8'h00;
      if (imm_drive) bus = imm_out;
      for (int i = 0; i < 4; i++) if (enable[i]) bus = regs[i];
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) if (latch[i]) regs[i] <= bus;
   end

   // Strobe invariants and pulse counting every cycle
   always @(negedge clk) begin
      if (reset) begin
         if ($countones(enable) > 1 || $countones(latch) > 1 || (imm_drive && |enable) ||
             (done && err) || ((done || err) && (|enable || |latch || imm_drive)))
            viol++;
         if (done) done_cnt++;
         if (err)  err_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void apply_model(input vec_t v);
      logic [7:0] val;
      if (!v.ie && v.s == v.d) return;
      val = v.ie ? v.imm : m_regs[v.s];
      m_regs[v.d] = val;
      m_last = val;
   endfunction

   // Present a request, wait for acceptance; returns #1 after the accept edge
   task automatic drive_req(input vec_t v);
      int cyc;
      cyc = 0;
      req_valid  = 1'b1;
      req_imm_en = v.ie;
      req_src    = v.s;
      req_dst    = v.d;
      req_imm    = v.imm;
      while (!req_ready && cyc < 20) begin
         step();
         cyc++;
      end
      chk("accept_wait", 32'(cyc < 20), 32'd1);
      step();
      req_valid = 1'b0;
      apply_model(v);
   endtask

   task automatic xfer(input vec_t v);
      logic [3:0] e_en;
      logic [3:0] e_lat;
      logic       bad;
      bad   = !v.ie && (v.s == v.d);
      e_en  = v.ie ? 4'h0 : 4'(1 << v.s);
      e_lat = 4'(1 << v.d);
      drive_req(v);
      if (bad) begin
         chk("err_pulse",     32'(err),       32'd1);
         chk("err_no_done",   32'(done),      32'd0);
         chk("err_enable",    32'(enable),    32'd0);
         chk("err_latch",     32'(latch),     32'd0);
         chk("err_imm_drive", 32'(imm_drive), 32'd0);
         chk("err_ready_low", 32'(req_ready), 32'd0);
         step();
         chk("err_ready_back", 32'(req_ready), 32'd1);
         chk("err_clear",      32'(err),       32'd0);
         chk("err_last_data",  32'(last_data), 32'(v.last));
      end else begin
         chk("setup_enable",    32'(enable),    32'(e_en));
         chk("setup_latch",     32'(latch),     32'd0);
         chk("setup_imm_drive", 32'(imm_drive), 32'(v.ie));
         chk("setup_ready",     32'(req_ready), 32'd0);
         step();
         chk("latch_enable",    32'(enable),    32'(e_en));
         chk("latch_imm_drive", 32'(imm_drive), 32'(v.ie));
         chk("latch_strobe",    32'(latch),     32'(e_lat));
         step();
         chk("done_strobes", 32'({enable, latch, imm_drive}), 32'd0);
         chk("done_pulse",   32'(done),      32'd1);
         chk("done_no_err",  32'(err),       32'd0);
         chk("last_data",    32'(last_data), 32'(v.last));
         step();
         chk("ready_at_n3", 32'(req_ready), 32'd1);
         chk("done_clear",  32'(done),      32'd0);
      end
   endtask

   initial begin
      vec_t vecs [7];
      vec_t v;
      int   dc;
      int   cyc;
      int   d0;
      int   e0;
      int   exp_done;
      int   exp_err;

      vecs[0] = '{1'b1, 2'd0, 2'd0, 8'hAA, 8'hAA};
      vecs[1] = '{1'b1, 2'd0, 2'd0, 8'h55, 8'h55};
      vecs[2] = '{1'b0, 2'd0, 2'd1, 8'h00, 8'h55};
      vecs[3] = '{1'b0, 2'd2, 2'd2, 8'h00, 8'h55};
      vecs[4] = '{1'b0, 2'd2, 2'd3, 8'h00, 8'h33};
      vecs[5] = '{1'b1, 2'd1, 2'd2, 8'h0F, 8'h0F};
      vecs[6] = '{1'b0, 2'd3, 2'd0, 8'h00, 8'h33};

      reset      = 1'b0;
      req_valid  = 1'b0;
      req_imm_en = 1'b0;
      req_src    = 2'd0;
      req_dst    = 2'd0;
      req_imm    = 8'h00;
      repeat (2) step();
      chk("rst_strobes",  32'({enable, latch, imm_drive}), 32'd0);
      chk("rst_pulses",   32'({done, err}), 32'd0);
      chk("rst_last",     32'(last_data), 32'd0);
      chk("rst_imm_out",  32'(imm_out), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_last_after", 32'(last_data), 32'd0);

      for (int i = 0; i < 7; i++) xfer(vecs[i]);

      // Reset asserted while the latch strobe is active
      v = '{1'b0, 2'(REG_A), 2'(REG_OUT), 8'h00, 8'h00};
      req_valid  = 1'b1;
      req_imm_en = v.ie;
      req_src    = v.s;
      req_dst    = v.d;
      cyc = 0;
      while (!req_ready && cyc < 20) begin
         step();
         cyc++;
      end
      step();
      req_valid = 1'b0;
      step();
      chk("mid_latch_on",  32'(latch),  32'h4);
      chk("mid_enable_on", 32'(enable), 32'h1);
      dc = done_cnt;
      #2 reset = 1'b0;
      #1;
      chk("mid_enable_drop", 32'(enable),    32'd0);
      chk("mid_latch_drop",  32'(latch),     32'd0);
      chk("mid_last_clear",  32'(last_data), 32'd0);
      chk("mid_no_done",     32'(done),      32'd0);
      repeat (2) step();
      @(negedge clk);
      reset = 1'b1;
      m_last = 8'h00;
      repeat (3) step();
      chk("abort_no_done", 32'(done_cnt), 32'(dc));
      chk("abort_ready",   32'(req_ready), 32'd1);
      chk("abort_reg_kept", 32'(regs[REG_OUT]), 32'(m_regs[REG_OUT]));
      v = '{1'b0, 2'(REG_TMP), 2'(REG_B), 8'h00, m_regs[REG_TMP]};
      xfer(v);

      // Randomized requests with idle gaps
      d0 = done_cnt;
      e0 = err_cnt;
      exp_done = 0;
      exp_err  = 0;
      for (int k = 0; k < 50; k++) begin
         repeat ($urandom_range(0, 3)) step();
         v.ie   = ($urandom_range(0, 2) == 0);
         v.s    = 2'($urandom_range(0, 3));
         v.d    = ($urandom_range(0, 3) == 0) ? v.s : 2'($urandom_range(0, 3));
         v.imm  = 8'($urandom);
         v.last = 8'h00;
         if (!v.ie && v.s == v.d) exp_err++;
         else exp_done++;
         drive_req(v);
         cyc = 0;
         while (!req_ready && cyc < 10) begin
            step();
            cyc++;
         end
         chk("rand_complete", 32'(cyc < 10), 32'd1);
         chk("rand_last_data", 32'(last_data), 32'(m_last));
      end
      repeat (3) step();
      chk("rand_done_count", 32'(done_cnt - d0), 32'(exp_done));
      chk("rand_err_count",  32'(err_cnt - e0),  32'(exp_err));
      for (int i = 0; i < 4; i++) chk("rand_reg_file", 32'(regs[i]), 32'(m_regs[i]));
      chk("strobe_invariants", 32'(viol), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
